mem_responder: RTL and testbench

- Memory-side responder for `datapath_cache_if`: serves the datapath's instruction fetches and data loads/stores.
- Arbitrates both request streams onto one shared RAM port and returns single-cycle `ihit`/`dhit` pulses with load data.
- Sits between the datapath and the RAM model; replaces the cache during single-cycle bring-up.
- Data requests take priority over instruction requests. A halted datapath gets no further fetches.

---
 rtl/cpu_types_pkg.sv | 6 +
 rtl/access_watchdog.sv | 23 ++
 rtl/mem_responder.sv | 103 ++++++++++
 tb/tb_mem_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, RAM handshake and responder FSM types
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
  typedef enum logic [2:0] {IDLE, DACC, IACC, DRESP, IRESP} resp_state_t;
endpackage

// File: rtl/access_watchdog.sv
// access_watchdog: saturating wait counter flagging an over-long RAM access
module access_watchdog #(
  parameter int TIMEOUT = 255,
  localparam int TO_W = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic expired
);
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            at_max;
  always_comb begin
    at_max  = cnt_q == TO_W'(TIMEOUT);
    cnt_d   = clr ? '0 : (inc && !at_max) ? cnt_q + 1'b1 : cnt_q;
    expired = at_max;
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: serves datapath fetches and data accesses over one shared RAM port
module mem_responder
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  input  logic        halt,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);
  resp_state_t state_q, state_d;
  word_t       addr_q, addr_d, store_q, store_d, iload_q, iload_d, dload_q, dload_d;
  logic        wr_q, wr_d, err_q, err_d;
  logic        in_acc, inc, clr, expired;
  ramstate_t   rs;
  assign rs = ramstate_t'(ramstate);
  access_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(CLK), .rst(RST), .inc(inc), .clr(clr), .expired(expired)
  );
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      wr_q    <= 1'b0;
      iload_q <= '0;
      dload_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      wr_q    <= wr_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
      err_q   <= err_d;
    end
  end
  // Data has priority; a halted datapath is never offered another fetch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    store_d = store_q;
    wr_d    = wr_q;
    iload_d = iload_q;
    dload_d = dload_q;
    in_acc  = state_q == DACC || state_q == IACC;
    inc     = in_acc && (rs == FREE || rs == BUSY);
    clr     = state_q == DRESP || state_q == IRESP;
    err_d   = err_q || expired || (in_acc && rs == ERROR);
    case (state_q)
      IDLE:
        if (dmemREN || dmemWEN) begin
          state_d = DACC;
          addr_d  = dmemaddr;
          store_d = dmemstore;
          wr_d    = dmemWEN;
        end else if (imemREN && !halt) begin
          state_d = IACC;
          addr_d  = imemaddr;
        end
      DACC:
        if (rs == ACCESS) begin
          state_d = DRESP;
          dload_d = wr_q ? dload_q : ramload;
        end
      IACC:
        if (rs == ACCESS) begin
          state_d = IRESP;
          iload_d = ramload;
        end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    ramREN   = (state_q == DACC && !wr_q) || state_q == IACC;
    ramWEN   = state_q == DACC && wr_q;
    ramaddr  = addr_q;
    ramstore = store_q;
    ihit     = state_q == IRESP;
    dhit     = state_q == DRESP;
    imemload = iload_q;
    dmemload = dload_q;
    err      = err_q;
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed vector bench for mem_responder against a small RAM model
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        iren, dren, dwen, halt;
  logic [31:0] iaddr, daddr, dstore;
  logic        ihit, dhit, ramREN, ramWEN, err;
  logic [31:0] imemload, dmemload, ramaddr, ramstore, ramload;
  logic [1:0]  ram_state;
  logic [31:0] mem [0:255];
  int          ram_waits, wcnt;
  logic        err_inject;
  int          total, bad;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] store;
    int          waits;
    int          lat;
    logic [31:0] val;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  mem_responder #(.TIMEOUT(4)) dut (
    .CLK(clk), .RST(rst),
    .imemREN(iren), .imemaddr(iaddr), .ihit(ihit), .imemload(imemload),
    .dmemREN(dren), .dmemWEN(dwen), .dmemaddr(daddr), .dmemstore(dstore),
    .dhit(dhit), .dmemload(dmemload), .halt(halt),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ram_state), .err(err)
  );

  assign ram_state = !(ramREN || ramWEN) ? 2'd0 : err_inject ? 2'd3 : (wcnt >= ram_waits) ? 2'd2 : 2'd1;
  assign ramload   = mem[ramaddr[9:2]];
  always @(posedge clk) wcnt <= ((ramREN || ramWEN) && ram_state != 2'd2) ? wcnt + 1 : 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_hit(output int lat, output logic isd, output logic ren, output logic wen,
                          output logic [31:0] raddr, output logic [31:0] rstore);
    lat = 41; isd = 1'b0; ren = 1'b0; wen = 1'b0; raddr = '0; rstore = '0;
    @(posedge clk);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        ren = ramREN; wen = ramWEN; raddr = ramaddr; rstore = ramstore;
      end
      if (ihit || dhit) begin
        lat = i;
        isd = dhit;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int          lat, quiet;
    logic        isd, ren, wen;
    logic [31:0] raddr, rstore;
    total = 0; bad = 0;
    rst = 1'b1; iren = 0; dren = 0; dwen = 0; halt = 0;
    iaddr = 0; daddr = 0; dstore = 0; ram_waits = 0; err_inject = 0; wcnt = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_0000 | i;
    mem[8'h10] = 32'h2402_0001;
    mem[8'h11] = 32'h8C22_0004;
    mem[8'h40] = 32'h0000_1234;
    mem[8'h20] = 32'h0BAD_F00D;
    mem[8'h04] = 32'h00C0_FFEE;
    mem[8'h30] = 32'h5555_AAAA;
    vecs[0] = '{0, 32'h40,  32'h0,         0, 2, 32'h2402_0001};
    vecs[1] = '{2, 32'h80,  32'hDEAD_BEEF, 0, 2, 32'hDEAD_BEEF};
    vecs[2] = '{1, 32'h80,  32'h0,         1, 3, 32'h0BAD_F00D};
    vecs[3] = '{1, 32'h100, 32'h0,         3, 5, 32'h0000_1234};
    vecs[4] = '{0, 32'h44,  32'h0,         2, 4, 32'h8C22_0004};
    vecs[5] = '{2, 32'h84,  32'h1357_9BDF, 2, 4, 32'h1357_9BDF};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_flags", {27'd0, ihit, dhit, ramREN, ramWEN, err}, 32'd0);
    chk("rst_words", ramaddr | ramstore | imemload | dmemload, 32'd0);
    rst = 1'b0;
    quiet = 0;
    repeat (10) begin
      @(negedge clk);
      if (ihit || dhit || ramREN || ramWEN || err || (ramaddr | ramstore | imemload | dmemload) != 0) quiet++;
    end
    chk("idle_quiet", quiet, 0);
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      ram_waits = vecs[v].waits;
      iren = vecs[v].kind == 0; dren = vecs[v].kind == 1; dwen = vecs[v].kind == 2;
      iaddr = vecs[v].addr; daddr = vecs[v].addr; dstore = vecs[v].store;
      wait_hit(lat, isd, ren, wen, raddr, rstore);
      iren = 0; dren = 0; dwen = 0;
      chk($sformatf("v%0d_lat", v), lat, vecs[v].lat);
      chk($sformatf("v%0d_kind", v), {31'd0, isd}, {31'd0, vecs[v].kind != 0});
      chk($sformatf("v%0d_addr", v), raddr, vecs[v].addr);
      chk($sformatf("v%0d_en", v), {30'd0, ren, wen}, vecs[v].kind == 2 ? 32'd1 : 32'd2);
      chk($sformatf("v%0d_val", v),
          vecs[v].kind == 0 ? imemload : vecs[v].kind == 1 ? dmemload : rstore, vecs[v].val);
    end
    @(negedge clk);
    chk("hold_dload", dmemload, 32'h0000_1234);
    chk("hold_iload", imemload, 32'h8C22_0004);
    chk("no_err", {31'd0, err}, 32'd0);
    // simultaneous store and fetch: store first, fetch after the turnaround
    ram_waits = 0;
    dwen = 1; daddr = 32'h80; dstore = 32'hDEAD_BEEF; iren = 1; iaddr = 32'h40;
    wait_hit(lat, isd, ren, wen, raddr, rstore);
    dwen = 0;
    chk("pri_dhit", {31'd0, isd}, 32'd1);
    chk("pri_wen", {30'd0, ren, wen}, 32'd1);
    chk("pri_store", rstore, 32'hDEAD_BEEF);
    lat = 21;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (ihit) begin
        lat = j;
        break;
      end
    end
    iren = 0;
    chk("pri_ihit_gap", lat, 3);
    chk("pri_iload", imemload, 32'h2402_0001);
    // long wait trips the watchdog but the load still completes
    @(negedge clk);
    ram_waits = 6; dren = 1; daddr = 32'hC0;
    @(posedge clk);
    lat = 41;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 2) chk("to_err_early", {31'd0, err}, 32'd0);
      if (dhit) begin
        lat = i;
        break;
      end
    end
    dren = 0;
    chk("to_lat", lat, 8);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_dload", dmemload, 32'h5555_AAAA);
    repeat (3) @(negedge clk);
    chk("to_err_sticky", {31'd0, err}, 32'd1);
    do_reset();
    chk("rst_err_clr", {31'd0, err}, 32'd0);
    chk("rst_dload_clr", dmemload, 32'd0);
    // one ERROR cycle flags err and re-issues the same access
    @(negedge clk);
    ram_waits = 1; dren = 1; daddr = 32'h100;
    @(posedge clk);
    @(negedge clk);
    err_inject = 1;
    daddr = 32'h200;
    @(negedge clk);
    err_inject = 0;
    chk("rerr_err", {31'd0, err}, 32'd1);
    chk("rerr_addr", ramaddr, 32'h100);
    chk("rerr_reissue", {30'd0, ramREN, dhit}, 32'd2);
    @(negedge clk);
    dren = 0;
    chk("rerr_dhit", {31'd0, dhit}, 32'd1);
    chk("rerr_dload", dmemload, 32'h0000_1234);
    do_reset();
    // halted datapath: fetches blocked, data still served
    ram_waits = 0; halt = 1; iren = 1; iaddr = 32'h40;
    quiet = 0;
    repeat (20) begin
      @(negedge clk);
      if (ihit || ramREN) quiet++;
    end
    chk("halt_quiet", quiet, 0);
    dren = 1; daddr = 32'h10;
    wait_hit(lat, isd, ren, wen, raddr, rstore);
    dren = 0;
    chk("halt_dlat", lat, 2);
    chk("halt_dkind", {31'd0, isd}, 32'd1);
    chk("halt_dload", dmemload, 32'h00C0_FFEE);
    quiet = 0;
    repeat (5) begin
      @(negedge clk);
      if (ihit || ramREN) quiet++;
    end
    chk("halt_no_fetch", quiet, 0);
    // reset mid-access abandons it without a hit
    ram_waits = 10; dren = 1; daddr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    chk("mid_in_dacc", {31'd0, ramREN}, 32'd1);
    rst = 1; dren = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("mid_rst", {29'd0, dhit, ramREN, ramWEN}, 32'd0);
    quiet = 0;
    repeat (12) begin
      @(negedge clk);
      if (dhit || ihit || ramREN) quiet++;
    end
    chk("mid_no_hit", quiet, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
